aerin_spike_sequencer: RTL and testbench
========================================

# aerin_spike_sequencer

Buffers host spike events for one sample, serialises them onto the core's 4-phase AERIN request/acknowledge channel and tracks the time-step position within the sample. It sits between the host/input-encoder stream and the AERIN port of `top_lrf_odins`. It issues neuron-spike events (type `2'b00`) and end-of-time-step markers (type `2'b01`), and flags sample completion after TIME_STEP markers.

## Interface
- FM_W, 16, input feature-map width
- FM_H, 16, input feature-map height
- FM_C, 3, input feature-map channels
- TIME_STEP, 8, time steps per sample (≥2)
- FIFO_DEPTH, 16, event FIFO entries (power of 2)
- SETUP_CYC, 2, cycles AERIN_ADDR is held stable before AERIN_REQ rises (≥1)
- TIMEOUT_CYC, 1024, REQ-high cycles without ACK before ERR is set
- Derived: PW = $clog2(FM_C)+$clog2(FM_H)+$clog2(FM_W); AW = PW+2; TW = $clog2(TIME_STEP)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- S_VALID  in  1  host event valid
- S_READY  out  1  FIFO can accept an event
- S_EOT  in  1  1 = end-of-time-step marker, payload ignored
- S_PIX  in  PW  pixel index {c,y,x}
- AERIN_REQ  out  1  4-phase request to core
- AERIN_ADDR  out  AW  {type[1:0], payload[PW-1:0]}
- AERIN_ACK  in  1  4-phase acknowledge from core (asynchronous)
- TS_IDX  out  TW  index of the current time step
- SAMPLE_DONE  out  1  one-cycle pulse after the last marker's handshake
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  occupied entries
- BUSY  out  1  FIFO non-empty or FSM not in IDLE
- ERR  out  1  sticky ACK timeout flag

## Operation
- FIFO entry = {eot, pix}. Push when S_VALID && S_READY. S_READY = (FIFO_LEVEL < FIFO_DEPTH).
- AERIN_ACK passes through a 2-flop synchroniser to ack_s. The FSM uses only ack_s.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head and go to SETUP.
  - SETUP: latch AERIN_ADDR = eot ? {2'b01, PW'0} : {2'b00, pix}; count SETUP_CYC cycles, then go to REQ.
  - REQ: drive AERIN_REQ=1 and wait for ack_s=1, then go to REL.
  - REL: drive AERIN_REQ=0 and wait for ack_s=0. If the entry was a marker, advance the time step. Then go to IDLE.
- AERIN_ADDR stays constant from SETUP through REL and only changes on entry to SETUP.
- Time-step advance on a marker:
  - TS_IDX < TIME_STEP-1: TS_IDX+1.
  - TS_IDX = TIME_STEP-1: TS_IDX wraps to 0 and SAMPLE_DONE pulses.
- An empty time step (marker with no spikes before it) is legal and is counted.
- Timeout: a counter runs while in REQ with ack_s=0. When it reaches TIMEOUT_CYC, ERR is set. The FSM keeps waiting in REQ; the protocol is never aborted. ERR clears only on reset.
- Push and pop in the same cycle leave FIFO_LEVEL unchanged. A push while full is impossible because S_READY=0.

## Timing
- Reset (rst=0 at an edge) returns to IDLE, from any state including mid-handshake. Reset values: AERIN_REQ=0, AERIN_ADDR=0, TS_IDX=0, SAMPLE_DONE=0, FIFO_LEVEL=0, S_READY=1, BUSY=0, ERR=0. FIFO contents and synchroniser flops are cleared.
- First-event latency, empty FIFO and FSM in IDLE:
  - push at edge t.
  - pop and SETUP entry at t+1; AERIN_ADDR valid after t+1.
  - AERIN_REQ=1 after edge t+1+SETUP_CYC.
- ACK to REQ response:
  - ACK rising seen by ack_s 2 edges later; AERIN_REQ falls at the next edge.
  - ACK falling: ack_s 2 edges later; state returns to IDLE at the next edge.
- Back-to-back events: next SETUP begins 1 cycle after leaving REL.
- SAMPLE_DONE: high for exactly the cycle after the REL→IDLE edge of the last marker, coincident with TS_IDX returning to 0.
- S_READY is combinational from FIFO_LEVEL.

## Test plan
- Reset mid-handshake: assert rst=0 while AERIN_REQ=1 → next edge REQ=0, ADDR=0, FIFO_LEVEL=0, TS_IDX=0.
- Single spike, pix=0x123, core auto-ACK delayed 50 cycles:
  - AERIN_ADDR=0x123 stable for ≥SETUP_CYC cycles before REQ rises.
  - REQ falls 3 edges after ACK rises.
- Full sample, 8 steps × 256 spikes each followed by a marker, bench ACK delay 12 cycles:
  - exactly 2048 type-00 events and 8 events of 0x400.
  - TS_IDX steps 0→7→0; SAMPLE_DONE pulses once.
- FIFO backpressure: ACK held low while 20 events are pushed → S_READY=0 at FIFO_LEVEL=16 (default depth), no event lost or reordered after ACK resumes.
- Empty time steps: 8 consecutive markers only → 8 handshakes of addr 0x400, one SAMPLE_DONE.
- Timeout: ACK never rises with TIMEOUT_CYC=1024 → ERR rises 1024 cycles into REQ, REQ stays high, a late ACK completes the handshake, ERR stays 1.

Source files
------------

// File: rtl/aerin_spike_sequencer.sv
// Buffers host spike/marker events in a FIFO and serialises them onto the 4-phase
// AERIN request/acknowledge channel, tracking the time-step position within a sample.
module aerin_spike_sequencer #(
   parameter  int unsigned FM_W        = 16,
   parameter  int unsigned FM_H        = 16,
   parameter  int unsigned FM_C        = 3,
   parameter  int unsigned TIME_STEP   = 8,
   parameter  int unsigned FIFO_DEPTH  = 16,
   parameter  int unsigned SETUP_CYC   = 2,
   parameter  int unsigned TIMEOUT_CYC = 1024,
   localparam int unsigned PW  = $clog2(FM_C) + $clog2(FM_H) + $clog2(FM_W),
   localparam int unsigned AW  = PW + 2,
   localparam int unsigned TW  = $clog2(TIME_STEP),
   localparam int unsigned LW  = $clog2(FIFO_DEPTH),
   localparam int unsigned LVW = LW + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           S_VALID,
   output logic           S_READY,
   input  logic           S_EOT,
   input  logic [PW-1:0]  S_PIX,
   output logic           AERIN_REQ,
   output logic [AW-1:0]  AERIN_ADDR,
   input  logic           AERIN_ACK,
   output logic [TW-1:0]  TS_IDX,
   output logic           SAMPLE_DONE,
   output logic [LVW-1:0] FIFO_LEVEL,
   output logic           BUSY,
   output logic           ERR
);

   localparam int unsigned SCW = $clog2(SETUP_CYC + 1);
   localparam int unsigned TOW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_REQ, ST_REL} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [PW:0]    r_mem [FIFO_DEPTH];
   logic [LW-1:0]  r_wptr;
   logic [LW-1:0]  r_rptr;
   logic [LVW-1:0] r_level;
   logic           r_ack_m;
   logic           r_ack_s;
   logic           r_req;
   logic [AW-1:0]  r_addr;
   logic           r_eot;
   logic [SCW-1:0] r_setup_cnt;
   logic [TOW-1:0] r_to_cnt;
   logic [TW-1:0]  r_ts;
   logic           r_done;
   logic           r_err;
   logic           w_ready;
   logic           w_push;
   logic           w_pop;
   logic           w_adv;
   logic [PW:0]    w_head;

   assign w_ready = (r_level < LVW'(FIFO_DEPTH));
   assign w_push  = S_VALID && w_ready;
   assign w_head  = r_mem[r_rptr];

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state and handshake control
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_adv       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_level != '0) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (r_setup_cnt == SCW'(SETUP_CYC - 1)) w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (r_ack_s) w_state_nxt = ST_REL;
         end
         ST_REL: begin
            if (!r_ack_s) begin
               w_state_nxt = ST_IDLE;
               w_adv       = r_eot;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FIFO, synchroniser, address latch, counters and flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         r_ack_m     <= 1'b0;
         r_ack_s     <= 1'b0;
         r_req       <= 1'b0;
         r_addr      <= '0;
         r_eot       <= 1'b0;
         r_setup_cnt <= '0;
         r_to_cnt    <= '0;
         r_ts        <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_ack_m <= AERIN_ACK;
         r_ack_s <= r_ack_m;
         r_req   <= (w_state_nxt == ST_REQ);
         r_done  <= 1'b0;

         if (w_push) begin
            r_mem[r_wptr] <= {S_EOT, S_PIX};
            r_wptr        <= r_wptr + LW'(1);
         end

         if (w_pop) begin
            r_rptr      <= r_rptr + LW'(1);
            r_eot       <= w_head[PW];
            r_addr      <= w_head[PW] ? {2'b01, PW'(0)} : {2'b00, w_head[PW-1:0]};
            r_setup_cnt <= '0;
         end

         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LVW'(1);
            2'b01:   r_level <= r_level - LVW'(1);
            default: r_level <= r_level;
         endcase

         if (r_state == ST_SETUP) begin
            r_setup_cnt <= r_setup_cnt + SCW'(1);
            r_to_cnt    <= '0;
         end

         // Timeout only flags the stall; the handshake keeps waiting for ACK
         if (r_state == ST_REQ && !r_ack_s) begin
            if (r_to_cnt != TOW'(TIMEOUT_CYC)) r_to_cnt <= r_to_cnt + TOW'(1);
            if (r_to_cnt == TOW'(TIMEOUT_CYC - 1)) r_err <= 1'b1;
         end

         if (w_adv) begin
            if (r_ts == TW'(TIME_STEP - 1)) begin
               r_ts   <= '0;
               r_done <= 1'b1;
            end else begin
               r_ts <= r_ts + TW'(1);
            end
         end
      end
   end

   assign S_READY     = w_ready;
   assign AERIN_REQ   = r_req;
   assign AERIN_ADDR  = r_addr;
   assign TS_IDX      = r_ts;
   assign SAMPLE_DONE = r_done;
   assign FIFO_LEVEL  = r_level;
   assign BUSY        = (r_level != '0) || (r_state != ST_IDLE);
   assign ERR         = r_err;

endmodule

// File: tb/tb_aerin_spike_sequencer.sv
// Scoreboard bench for aerin_spike_sequencer: random spike/marker streams, an emulated
// core acknowledging with configurable delay, and a monitor checking every handshake.
module tb_aerin_spike_sequencer;

   localparam int unsigned PW    = 10;
   localparam int unsigned AW    = 12;
   localparam int unsigned TW    = 3;
   localparam int unsigned LVW   = 5;
   localparam int unsigned TS_N  = 8;
   localparam int unsigned SETUP = 2;
   localparam logic [AW-1:0] MARK = 12'h400;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           S_VALID = 1'b0;
   logic           S_READY;
   logic           S_EOT = 1'b0;
   logic [PW-1:0]  S_PIX = '0;
   logic           AERIN_REQ;
   logic [AW-1:0]  AERIN_ADDR;
   logic           AERIN_ACK = 1'b0;
   logic [TW-1:0]  TS_IDX;
   logic           SAMPLE_DONE;
   logic [LVW-1:0] FIFO_LEVEL;
   logic           BUSY;
   logic           ERR;

   always #5 clk = ~clk;

   aerin_spike_sequencer dut (
      .clk(clk), .rst(rst), .S_VALID(S_VALID), .S_READY(S_READY), .S_EOT(S_EOT),
      .S_PIX(S_PIX), .AERIN_REQ(AERIN_REQ), .AERIN_ADDR(AERIN_ADDR),
      .AERIN_ACK(AERIN_ACK), .TS_IDX(TS_IDX), .SAMPLE_DONE(SAMPLE_DONE),
      .FIFO_LEVEL(FIFO_LEVEL), .BUSY(BUSY), .ERR(ERR)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [AW-1:0] exp_q[$];
   int            markers_seen = 0;
   int            spikes_seen  = 0;
   int            done_cnt     = 0;
   int            stable       = 0;
   logic          prev_req     = 1'b0;
   logic          prev_done    = 1'b0;
   logic [AW-1:0] prev_addr    = '0;
   logic [AW-1:0] held_addr    = '0;
   bit            hold_ack     = 1'b0;
   bit            chk_lat      = 1'b0;
   int            ack_delay    = 12;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [PW-1:0] rand_pix();
      return {2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom)};
   endfunction

   // Monitor: every REQ rise is one handshake; compare against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         prev_req     = 1'b0;
         prev_done    = 1'b0;
         stable       = 0;
         prev_addr    = AERIN_ADDR;
         markers_seen = 0;
         done_cnt     = 0;
      end else begin
         if (AERIN_ADDR !== prev_addr) stable = 0;
         else stable++;
         prev_addr = AERIN_ADDR;
         if (AERIN_REQ && !prev_req) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_req: got addr 0x%0h with empty scoreboard", AERIN_ADDR);
            end else begin
               check("event_addr", 32'(AERIN_ADDR), 32'(exp_q.pop_front()));
            end
            check("addr_setup_stable", 32'(stable >= SETUP), 1);
            check("ts_at_req", 32'(TS_IDX), markers_seen % TS_N);
            check("done_count_at_req", done_cnt, markers_seen / TS_N);
            held_addr = AERIN_ADDR;
            if (AERIN_ADDR == MARK) markers_seen++;
            else if (AERIN_ADDR[AW-1:PW] == 2'b00) spikes_seen++;
         end else if (AERIN_REQ) begin
            check("addr_hold_in_req", 32'(AERIN_ADDR), 32'(held_addr));
         end
         prev_req = AERIN_REQ;
         if (SAMPLE_DONE) begin
            done_cnt++;
            check("done_with_ts_zero", 32'(TS_IDX), 0);
            check("done_single_cycle", 32'(prev_done), 0);
         end
         prev_done = SAMPLE_DONE;
      end
   end

   // Emulated core: acknowledge REQ after ack_delay cycles, drop ACK once REQ falls
   initial begin
      int n;
      forever begin
         @(negedge clk);
         if (rst && AERIN_REQ && !hold_ack) begin
            repeat (ack_delay) @(posedge clk);
            #1 AERIN_ACK = 1'b1;
            n = 0;
            while (AERIN_REQ === 1'b1 && n < 2000) begin
               @(posedge clk);
               n++;
               #1;
            end
            if (chk_lat) check("req_fall_after_ack", n, 3);
            repeat (2) @(posedge clk);
            #1 AERIN_ACK = 1'b0;
         end
      end
   end

   task automatic push(input bit eot, input logic [PW-1:0] pix);
      int w = 0;
      @(negedge clk);
      S_VALID = 1'b1;
      S_EOT   = eot;
      S_PIX   = pix;
      while (!S_READY && w < 5000) begin
         @(negedge clk);
         w++;
      end
      if (!S_READY) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: S_READY stuck at 0, level %0d", FIFO_LEVEL);
         S_VALID = 1'b0;
         return;
      end
      exp_q.push_back(eot ? MARK : {2'b00, pix});
      @(posedge clk);
      #1 S_VALID = 1'b0;
   endtask

   task automatic drain();
      int w = 0;
      while ((BUSY || exp_q.size() != 0 || AERIN_ACK) && w < 100000) begin
         @(negedge clk);
         w++;
      end
      repeat (2) @(negedge clk);
      check("drain_idle", 32'(BUSY), 0);
      check("scoreboard_empty", exp_q.size(), 0);
      check("ts_after_drain", 32'(TS_IDX), markers_seen % TS_N);
      check("done_after_drain", done_cnt, markers_seen / TS_N);
   endtask

   task automatic wait_req(output int n);
      n = 0;
      while (!AERIN_REQ && n < 200) begin
         @(posedge clk);
         n++;
         #1;
      end
   endtask

   initial begin
      int n, base_sp, base_mk;
      // Reset values
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req", 32'(AERIN_REQ), 0);
      check("rst_addr", 32'(AERIN_ADDR), 0);
      check("rst_ts", 32'(TS_IDX), 0);
      check("rst_done", 32'(SAMPLE_DONE), 0);
      check("rst_level", 32'(FIFO_LEVEL), 0);
      check("rst_ready", 32'(S_READY), 1);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_err", 32'(ERR), 0);
      @(negedge clk);
      rst = 1'b1;

      // Single spike, slow core
      chk_lat   = 1'b1;
      ack_delay = 50;
      push(1'b0, 10'h123);
      wait_req(n);
      check("first_req_latency", n, 1 + SETUP);
      check("first_addr", 32'(AERIN_ADDR), 32'h123);
      drain();
      chk_lat = 1'b0;

      // Full sample of random spikes plus one marker per step
      ack_delay = 12;
      base_sp   = spikes_seen;
      base_mk   = markers_seen;
      for (int s = 0; s < TS_N; s++) begin
         for (int i = 0; i < 256; i++) push(1'b0, rand_pix());
         push(1'b1, 10'($urandom));
      end
      drain();
      check("sample_spike_count", spikes_seen - base_sp, 2048);
      check("sample_marker_count", markers_seen - base_mk, TS_N);

      // Backpressure with ACK held low
      ack_delay = 3;
      hold_ack  = 1'b1;
      for (int i = 0; i < 17; i++) push(1'b0, rand_pix());
      @(negedge clk);
      check("bp_level_full", 32'(FIFO_LEVEL), 16);
      check("bp_ready_low", 32'(S_READY), 0);
      hold_ack = 1'b0;
      for (int i = 0; i < 3; i++) push(1'b0, rand_pix());
      drain();

      // Empty time steps
      base_mk = markers_seen;
      for (int i = 0; i < TS_N; i++) push(1'b1, 10'($urandom));
      drain();
      check("empty_marker_count", markers_seen - base_mk, TS_N);

      // ACK timeout, then late ACK
      hold_ack = 1'b1;
      push(1'b0, 10'h2AA);
      wait_req(n);
      check("to_req_high", 32'(AERIN_REQ), 1);
      repeat (1000) @(posedge clk);
      #1;
      check("to_err_early", 32'(ERR), 0);
      repeat (30) @(posedge clk);
      #1;
      check("to_err_set", 32'(ERR), 1);
      check("to_req_still_high", 32'(AERIN_REQ), 1);
      hold_ack = 1'b0;
      drain();
      check("to_err_sticky", 32'(ERR), 1);

      // Reset in the middle of a handshake, with nonzero time step and queued events
      push(1'b1, 10'h0);
      drain();
      check("pre_rst_ts", 32'(TS_IDX), 1);
      hold_ack = 1'b1;
      push(1'b0, 10'h005);
      push(1'b0, 10'h006);
      push(1'b0, 10'h007);
      wait_req(n);
      check("mid_req_high", 32'(AERIN_REQ), 1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      check("mid_rst_req", 32'(AERIN_REQ), 0);
      check("mid_rst_addr", 32'(AERIN_ADDR), 0);
      check("mid_rst_level", 32'(FIFO_LEVEL), 0);
      check("mid_rst_ts", 32'(TS_IDX), 0);
      check("mid_rst_err", 32'(ERR), 0);
      check("mid_rst_ready", 32'(S_READY), 1);
      @(negedge clk);
      rst      = 1'b1;
      hold_ack = 1'b0;
      push(1'b0, 10'h3FF);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
